aes_round_ctrl: RTL and testbench

- Sequencing controller for the AES-128 iterative encryption datapath: state register, SubBytes/ShiftRows/MixColumns, AddRoundKey and on-the-fly key expansion.
- Accepts a start request and steps the shared round hardware through round 0 (AddRoundKey only), rounds 1..NUM_ROUNDS-1 (full round) and the final round (MixColumns bypassed).
- Generates the round constant for the key schedule.
- Presents a valid/ready result handshake to the downstream consumer.

---
 rtl/aes_round_ctrl_if.sv | 27 ++
 rtl/aes_round_ctrl.sv | 138 +++++++++++++
 tb/tb_aes_round_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_if.sv
// Control bundle between the AES round sequencer and its datapath/requester.
// Latency: none, pure signal grouping.
// Backpressure: carries the iStart/oReady and oValid/iOutReady handshakes.
interface aes_round_ctrl_if;
  logic       iStart;
  logic       oReady;
  logic       oLoadSel;
  logic       oStateEn;
  logic       oKeyEn;
  logic       oMixBypass;
  logic [7:0] oRcon;
  logic [3:0] oRound;
  logic       oValid;
  logic       iOutReady;

  // Controller side
  modport master (
    input  iStart, iOutReady,
    output oReady, oLoadSel, oStateEn, oKeyEn, oMixBypass, oRcon, oRound, oValid
  );

  // Requester / datapath / consumer side
  modport slave (
    output iStart, iOutReady,
    input  oReady, oLoadSel, oStateEn, oKeyEn, oMixBypass, oRcon, oRound, oValid
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128 iterative round sequencer: load/enable/bypass/rcon control for a shared round datapath.
// Latency: oValid rises (NUM_ROUNDS+1)*ROUND_CYCLES cycles after the accepting start edge.
// Backpressure: result held in DONE until iOutReady; iStart is ignored unless oReady.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS   = 10,
  parameter int ROUND_CYCLES = 1
) (
  input logic              iClk,
  input logic              iRsn,
  aes_round_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;

  localparam logic [3:0] LAST_CYC = 4'(ROUND_CYCLES - 1);
  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);
  // With one cycle per round every round cycle is also its last, so the
  // enable pulse must be raised on the very edge that enters the round.
  localparam logic ONE_CYC  = (ROUND_CYCLES == 1);
  localparam logic SKIP_MID = (NUM_ROUNDS == 1);

  state_t     state;
  logic [3:0] cyc;
  logic       last;
  logic       pre_last;
  logic       to_final;

  assign last     = (cyc == LAST_CYC);
  assign pre_last = ((cyc + 4'd1) == LAST_CYC);
  assign to_final = ((bus.oRound + 4'd1) == LAST_RND);

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // FSM: outputs are registered and derived from the state/cyc being entered,
  // so each control value lines up with the cycle it describes.
  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      state          <= IDLE;
      cyc            <= '0;
      bus.oRound     <= '0;
      bus.oRcon      <= 8'h01;
      bus.oReady     <= 1'b1;
      bus.oStateEn   <= 1'b0;
      bus.oKeyEn     <= 1'b0;
      bus.oLoadSel   <= 1'b0;
      bus.oMixBypass <= 1'b0;
      bus.oValid     <= 1'b0;
    end else begin
      bus.oStateEn <= 1'b0;
      bus.oKeyEn   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iStart) begin
            state        <= INIT;
            cyc          <= '0;
            bus.oRound   <= '0;
            bus.oRcon    <= 8'h01;
            bus.oReady   <= 1'b0;
            bus.oLoadSel <= 1'b1;
            bus.oStateEn <= ONE_CYC;
            bus.oKeyEn   <= ONE_CYC;
          end
        end
        INIT: begin
          if (last) begin
            cyc          <= '0;
            bus.oRound   <= 4'd1;
            bus.oLoadSel <= 1'b0;
            bus.oStateEn <= ONE_CYC;
            if (SKIP_MID) begin
              state          <= FINAL;
              bus.oMixBypass <= 1'b1;
            end else begin
              state      <= ROUND;
              bus.oKeyEn <= ONE_CYC;
            end
          end else begin
            cyc          <= cyc + 4'd1;
            bus.oStateEn <= pre_last;
            bus.oKeyEn   <= pre_last;
          end
        end
        ROUND: begin
          if (last) begin
            cyc          <= '0;
            bus.oRound   <= bus.oRound + 4'd1;
            bus.oRcon    <= xtime(bus.oRcon);
            bus.oStateEn <= ONE_CYC;
            if (to_final) begin
              state          <= FINAL;
              bus.oMixBypass <= 1'b1;
            end else begin
              bus.oKeyEn <= ONE_CYC;
            end
          end else begin
            cyc          <= cyc + 4'd1;
            bus.oStateEn <= pre_last;
            bus.oKeyEn   <= pre_last;
          end
        end
        FINAL: begin
          if (last) begin
            state          <= DONE;
            cyc            <= '0;
            bus.oMixBypass <= 1'b0;
            bus.oValid     <= 1'b1;
          end else begin
            cyc          <= cyc + 4'd1;
            bus.oStateEn <= pre_last;
          end
        end
        DONE: begin
          // Ciphertext sits untouched in the state register until taken.
          if (bus.iOutReady) begin
            state      <= IDLE;
            bus.oValid <= 1'b0;
            bus.oReady <= 1'b1;
            bus.oRound <= '0;
            bus.oRcon  <= 8'h01;
          end
        end
        default: begin
          state          <= IDLE;
          cyc            <= '0;
          bus.oRound     <= '0;
          bus.oRcon      <= 8'h01;
          bus.oReady     <= 1'b1;
          bus.oLoadSel   <= 1'b0;
          bus.oMixBypass <= 1'b0;
          bus.oValid     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: two instances (1 and 3 cycles per round) each driving
// a behavioural AES-128 datapath; accepted starts push expectations, a monitor
// pops and compares when a result is handed off.
module tb_aes_round_ctrl;
  localparam int NR = 10;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks   = 0;
  int failures = 0;

  logic [1:0]      rsn;
  logic [1:0]      start;
  logic [1:0]      out_rdy;
  logic [1:0]      ready;
  logic [1:0]      valid;
  logic [1:0][3:0] round;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // ---------------- AES reference pieces ----------------
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic skip_mix);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] m0, m1, m2, m3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = st[127 - 8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[4*c + r] = sbox(a[4*((c + r) % 4) + r]);
    if (!skip_mix) begin
      for (int c = 0; c < 4; c++) begin
        m0 = b[4*c]; m1 = b[4*c+1]; m2 = b[4*c+2]; m3 = b[4*c+3];
        b[4*c]   = gmul(8'h02, m0) ^ gmul(8'h03, m1) ^ m2 ^ m3;
        b[4*c+1] = m0 ^ gmul(8'h02, m1) ^ gmul(8'h03, m2) ^ m3;
        b[4*c+2] = m0 ^ m1 ^ gmul(8'h02, m2) ^ gmul(8'h03, m3);
        b[4*c+3] = gmul(8'h03, m0) ^ m1 ^ m2 ^ gmul(8'h02, m3);
      end
    end
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = b[i];
    return o ^ rk;
  endfunction

  // Hand-computed round constants indexed by the round being executed.
  function automatic logic [7:0] exp_rcon(input logic [3:0] r);
    case (r)
      4'd0, 4'd1: return 8'h01;
      4'd2:  return 8'h02;
      4'd3:  return 8'h04;
      4'd4:  return 8'h08;
      4'd5:  return 8'h10;
      4'd6:  return 8'h20;
      4'd7:  return 8'h40;
      4'd8:  return 8'h80;
      4'd9:  return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- two DUT instances ----------------
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int RC  = (g == 0) ? 1 : 3;
    localparam int LAT = (NR + 1) * RC;

    aes_round_ctrl_if bus ();

    aes_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_CYCLES(RC)) dut (
      .iClk (clk),
      .iRsn (rsn[g]),
      .bus  (bus.master)
    );

    assign bus.iStart    = start[g];
    assign bus.iOutReady = out_rdy[g];
    assign ready[g]      = bus.oReady;
    assign valid[g]      = bus.oValid;
    assign round[g]      = bus.oRound;

    // Behavioural datapath steered only by the controller outputs.
    logic [127:0] st;
    logic [127:0] kr;
    always @(posedge clk) begin
      if (bus.oStateEn)
        st <= bus.oLoadSel ? (PT ^ KEY) : aes_round(st, expand(kr, bus.oRcon), bus.oMixBypass);
      if (bus.oKeyEn)
        kr <= bus.oLoadSel ? KEY : expand(kr, bus.oRcon);
    end

    int   acc_q[$];
    logic fresh = 1'b1;

    // Stimulus side: every accepted start pushes its accept cycle.
    always @(negedge clk) begin
      if (!rsn[g]) begin
        acc_q.delete();
        fresh <= 1'b1;
      end else if (start[g] && bus.oReady) begin
        acc_q.push_back(cycle + 1);
        fresh <= 1'b0;
      end
    end

    int   se_cnt   = 0;
    int   ke_cnt   = 0;
    int   last_se  = -1;
    logic prev_vld = 1'b0;

    // Monitor: per-cycle control checks and result scoreboard.
    always @(negedge clk) begin
      if (!rsn[g]) begin
        se_cnt   <= 0;
        ke_cnt   <= 0;
        last_se  <= -1;
        prev_vld <= 1'b0;
      end else begin
        if (fresh) begin
          check("idle_ready",  bus.oReady,     1'b1);
          check("idle_valid",  bus.oValid,     1'b0);
          check("idle_rcon",   bus.oRcon,      8'h01);
          check("idle_round",  bus.oRound,     4'd0);
          check("idle_stateen", bus.oStateEn,  1'b0);
          check("idle_keyen",  bus.oKeyEn,     1'b0);
          check("idle_loadsel", bus.oLoadSel,  1'b0);
        end
        check("mix_bypass", bus.oMixBypass,
              (bus.oRound == 4'(NR)) && !bus.oValid && !bus.oReady);
        if (bus.oStateEn) begin
          check("stateen_round", bus.oRound, se_cnt);
          check("rcon", bus.oRcon, exp_rcon(bus.oRound));
          check("loadsel", bus.oLoadSel, bus.oRound == 4'd0);
          check("keyen_with_state", bus.oKeyEn, bus.oRound != 4'(NR));
          if (last_se >= 0) check("stateen_spacing", cycle - last_se, RC);
          last_se <= cycle;
          se_cnt  <= se_cnt + 1;
        end
        if (bus.oKeyEn) ke_cnt <= ke_cnt + 1;
        if (bus.oValid) begin
          check("done_ready", bus.oReady, 1'b0);
          check("done_no_write", bus.oStateEn, 1'b0);
        end
        if (bus.oValid && !prev_vld) begin
          if (acc_q.size() == 0) fail("unexpected_valid");
          else check("latency", cycle - acc_q[0], LAT);
        end
        if (bus.oValid && out_rdy[g] && acc_q.size() != 0) begin
          check("ciphertext", st, CT);
          check("stateen_count", se_cnt, NR + 1);
          check("keyen_count", ke_cnt, NR);
          void'(acc_q.pop_front());
          se_cnt  <= 0;
          ke_cnt  <= 0;
          last_se <= -1;
        end
        prev_vld <= bus.oValid;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int k);
    int n;
    n = 0;
    start[k] = 1'b1;
    while (!ready[k] && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) fail("start_timeout");
    step();
    start[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (!ready[k] && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) fail("idle_timeout");
    repeat (2) step();
  endtask

  task automatic wait_valid(input int k);
    int n;
    n = 0;
    while (!valid[k] && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) fail("valid_timeout");
  endtask

  initial begin
    int n;
    rsn     = 2'b00;
    start   = 2'b00;
    out_rdy = 2'b11;
    repeat (3) step();
    rsn = 2'b11;
    repeat (5) step();

    // Known-answer block on each instance.
    do_start(0);
    wait_idle(0);
    do_start(1);
    wait_idle(1);

    // Stalled consumer with starts arriving during DONE.
    out_rdy[0] = 1'b0;
    do_start(0);
    wait_valid(0);
    for (int i = 0; i < 20; i++) begin
      start[0] = i[0];
      check("stall_valid", valid[0], 1'b1);
      check("stall_ready", ready[0], 1'b0);
      step();
    end
    // Release and start in the same DONE cycle: start taken on the next IDLE cycle.
    start[0]   = 1'b1;
    out_rdy[0] = 1'b1;
    n = 0;
    while (!ready[0] && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) fail("release_timeout");
    step();
    start[0] = 1'b0;
    check("held_start_taken", ready[0], 1'b0);
    wait_idle(0);

    // Reset in the middle of round 5 abandons the block.
    do_start(0);
    n = 0;
    while (round[0] != 4'd5 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) fail("round5_timeout");
    rsn[0] = 1'b0;
    step();
    rsn[0] = 1'b1;
    repeat (3) step();
    do_start(0);
    wait_idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
